// File: rtl/link_pkg.sv
// Shared types and helpers for the serial link receiver: FSM states, default
// word width and the bit-counter width function.
package link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FULL,
        DRAIN
    } link_state_e;

    localparam int LINK_WIDTH = 32;

    // Counter must hold 0..WIDTH+1 so an overlong frame stays distinguishable.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/link_sync.sv
// Multi-flop synchroniser for one asynchronous link line, with a history flop
// providing single-cycle rise and fall strobes in the clk domain.
module link_sync
    import link_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
            hist_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
            hist_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~hist_q;
    assign fall_o = ~sync_o & hist_q;

endmodule

// File: rtl/spi_link_receiver.sv
// Serial link front end: deserialises one word per chip-select frame and holds it
// until acknowledged. Define LINK_PARITY_EN for a trailing even-parity bit.
module spi_link_receiver
    import link_pkg::*;
#(
    parameter int WIDTH       = LINK_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk_in,
    input  logic             cs_in,
    input  logic             data_in,
    input  logic             ack_in,
    output logic [WIDTH-1:0] instr_out,
    output logic             check_out,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
`ifdef LINK_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic data_sync, data_rise, data_fall;
    logic unused_edges;

    link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .reset(reset), .async_i(sclk_in),
        .sync_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .reset(reset), .async_i(cs_in),
        .sync_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
        .clk(clk), .reset(reset), .async_i(data_in),
        .sync_o(data_sync), .rise_o(data_rise), .fall_o(data_fall)
    );

    assign unused_edges = ^{sclk_sync, sclk_fall, cs_sync, data_rise, data_fall};

    link_state_e      state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] instr_q;
    logic             check_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             frame_good;

`ifdef LINK_PARITY_EN
    logic par_q;
    assign frame_good = ((^sr_q) == par_q);
`else
    assign frame_good = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            instr_q     <= '0;
            check_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef LINK_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            if (ack_in) check_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_rise) begin
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_fall) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (sclk_rise) begin
`ifdef LINK_PARITY_EN
                        if (cnt_q == CNT_LAST) par_q <= data_sync;
                        else sr_q <= {sr_q[WIDTH-2:0], data_sync};
`else
                        sr_q <= {sr_q[WIDTH-2:0], data_sync};
`endif
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) state_q <= FULL;
                    end
                end
                FULL: begin
                    if (cs_fall) begin
                        state_q <= IDLE;
                        // An ack in the same cycle frees the slot for the new word.
                        if (!frame_good) begin
                            frame_err_q <= 1'b1;
                        end else if (!check_q || ack_in) begin
                            instr_q <= sr_q;
                            check_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        frame_err_q <= 1'b1;
                        state_q     <= DRAIN;
                        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DRAIN: begin
                    if (cs_fall) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_out = instr_q;
    assign check_out = check_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_link_receiver.sv
// Scoreboard bench for spi_link_receiver: directed frames queue expected words,
// a negedge monitor compares every delivery and counts frame_err pulses.
module tb_spi_link_receiver;
    import link_pkg::*;

    localparam int WIDTH = 32;
`ifdef LINK_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset, sclk_in, cs_in, data_in, ack_in;
    logic [WIDTH-1:0] instr_out;
    logic             check_out, frame_err, overrun, busy;

    int               errors = 0;
    int               checks = 0;
    int               frameErrCount = 0;
    int               errBefore;
    logic [WIDTH-1:0] expQ[$];

    spi_link_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sclk_in(sclk_in), .cs_in(cs_in),
        .data_in(data_in), .ack_in(ack_in), .instr_out(instr_out),
        .check_out(check_out), .frame_err(frame_err), .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [WIDTH+1:0] frameBits(input logic [WIDTH-1:0] word);
`ifdef LINK_PARITY_EN
        return {1'b0, word, ^word};
`else
        return {2'b00, word};
`endif
    endfunction

    // Drives one frame: sclk period 8 clk, data changed while sclk is low.
    task automatic applyStimulus(input logic [WIDTH+1:0] bits, input int nBits,
                                 input bit dropCs);
        cs_in = 1'b1;
        waitClocks(4);
        for (int i = nBits - 1; i >= 0; i--) begin
            data_in = bits[i];
            sclk_in = 1'b0;
            waitClocks(4);
            sclk_in = 1'b1;
            waitClocks(4);
        end
        sclk_in = 1'b0;
        waitClocks(4);
        if (dropCs) cs_in = 1'b0;
    endtask

    task automatic pulseAck();
        ack_in = 1'b1;
        waitClocks(1);
        ack_in = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every new word presented.
    initial begin
        logic             prevCheck;
        logic             prevFe;
        logic [WIDTH-1:0] prevInstr;
        prevCheck = 1'b0;
        prevFe    = 1'b0;
        prevInstr = '0;
        forever begin
            @(negedge clk);
            if (frame_err && prevFe) begin
                checks++;
                errors++;
                $display("[TB] FAIL frame_err width: high 2 cycles, expected 1");
            end
            if (frame_err && !prevFe) frameErrCount++;
            if (check_out && (!prevCheck || instr_out != prevInstr)) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected delivery: got 0x%08h, expected none", instr_out);
                end else begin
                    checkOutput("delivered word", instr_out, expQ.pop_front());
                end
            end
            prevCheck = check_out;
            prevFe    = frame_err;
            prevInstr = instr_out;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1; sclk_in = 1'b0; cs_in = 1'b0; data_in = 1'b0; ack_in = 1'b0;
        waitClocks(3);
        reset = 1'b0;
        waitClocks(1);
        checkOutput("reset instr_out", instr_out, 32'h0);
        checkOutput("reset check_out", 32'(check_out), 32'h0);
        checkOutput("reset frame_err", 32'(frame_err), 32'h0);
        checkOutput("reset overrun", 32'(overrun), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);

        // Basic frame with N+2 latency check.
        expQ.push_back(32'hDEADBEEF);
        applyStimulus(frameBits(32'hDEADBEEF), FRAME, 1'b1);
        waitClocks(2);
        checkOutput("check_out before N+2", 32'(check_out), 32'h0);
        waitClocks(1);
        checkOutput("check_out at N+2", 32'(check_out), 32'h1);
        checkOutput("instr_out at N+2", instr_out, 32'hDEADBEEF);
        checkOutput("frame_err count t1", 32'(frameErrCount), 32'h0);
        pulseAck();
        checkOutput("check_out after ack t1", 32'(check_out), 32'h0);

        // Delivery coinciding with ack replaces the held word without overrun.
        expQ.push_back(32'hCAFEF00D);
        applyStimulus(frameBits(32'hCAFEF00D), FRAME, 1'b1);
        waitClocks(4);
        expQ.push_back(32'h0BADC0DE);
        applyStimulus(frameBits(32'h0BADC0DE), FRAME, 1'b1);
        waitClocks(2);
        pulseAck();
        checkOutput("check_out after ack+deliver", 32'(check_out), 32'h1);
        checkOutput("instr_out after ack+deliver", instr_out, 32'h0BADC0DE);
        checkOutput("overrun after ack+deliver", 32'(overrun), 32'h0);
        pulseAck();

        // Overrun: second word dropped while first is unacknowledged.
        expQ.push_back(32'h00000001);
        applyStimulus(frameBits(32'h00000001), FRAME, 1'b1);
        waitClocks(4);
        applyStimulus(frameBits(32'hFFFFFFFF), FRAME, 1'b1);
        waitClocks(4);
        checkOutput("instr_out kept on overrun", instr_out, 32'h00000001);
        checkOutput("overrun set", 32'(overrun), 32'h1);
        pulseAck();
        checkOutput("check_out after ack t2", 32'(check_out), 32'h0);
        checkOutput("overrun sticky", 32'(overrun), 32'h1);

        // Short frame: 20 bits then cs drop.
        errBefore = frameErrCount;
        applyStimulus(frameBits(32'h000ABCDE), 20, 1'b1);
        waitClocks(4);
        checkOutput("frame_err count short", 32'(frameErrCount), 32'(errBefore + 1));
        checkOutput("check_out after short", 32'(check_out), 32'h0);
        checkOutput("busy after short", 32'(busy), 32'h0);
        expQ.push_back(32'h12345678);
        applyStimulus(frameBits(32'h12345678), FRAME, 1'b1);
        waitClocks(4);
        checkOutput("check_out after clean frame", 32'(check_out), 32'h1);
        pulseAck();

        // Overlong frame: error on the extra sclk edge, nothing delivered.
        errBefore = frameErrCount;
        applyStimulus(frameBits(32'h55AA55AA), FRAME, 1'b0);
        checkOutput("no frame_err at full count", 32'(frameErrCount), 32'(errBefore));
        applyStimulus({(WIDTH + 2){1'b1}}, 1, 1'b0);
        checkOutput("frame_err on extra edge", 32'(frameErrCount), 32'(errBefore + 1));
        checkOutput("busy in drain", 32'(busy), 32'h1);
        cs_in = 1'b0;
        waitClocks(4);
        checkOutput("busy after drain", 32'(busy), 32'h0);
        checkOutput("check_out after overlong", 32'(check_out), 32'h0);
        checkOutput("frame_err count overlong", 32'(frameErrCount), 32'(errBefore + 1));

        // Reset mid-frame aborts silently.
        applyStimulus(frameBits(32'hFFFF0000), 16, 1'b0);
        errBefore = frameErrCount;
        reset = 1'b1;
        cs_in = 1'b0;
        waitClocks(3);
        reset = 1'b0;
        waitClocks(3);
        checkOutput("busy after mid-frame reset", 32'(busy), 32'h0);
        checkOutput("check_out after mid-frame reset", 32'(check_out), 32'h0);
        expQ.push_back(32'hA5A5A5A5);
        applyStimulus(frameBits(32'hA5A5A5A5), FRAME, 1'b1);
        waitClocks(4);
        checkOutput("instr_out after reset frame", instr_out, 32'hA5A5A5A5);
        checkOutput("frame_err count reset", 32'(frameErrCount), 32'(errBefore));
        pulseAck();

`ifdef LINK_PARITY_EN
        expQ.push_back(32'h00000003);
        applyStimulus({2'b00, 32'h00000003, 1'b0}, FRAME, 1'b1);
        waitClocks(4);
        checkOutput("parity good delivered", 32'(check_out), 32'h1);
        pulseAck();
        errBefore = frameErrCount;
        applyStimulus({2'b00, 32'h00000007, 1'b0}, FRAME, 1'b1);
        waitClocks(4);
        checkOutput("parity bad frame_err", 32'(frameErrCount), 32'(errBefore + 1));
        checkOutput("parity bad not delivered", 32'(check_out), 32'h0);
`endif

        waitClocks(4);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_link_receiver.md
Name: spi_link_receiver

Overview:
- Per-port serial front end feeding one receiver_queue input (left, right or self).
- Deserialises one instruction word from a neighbour node's serial link: clock, chip-select and data lines, all asynchronous to the local clk.
- Presents the word with a level "check" flag that is held until the queue acknowledges it.
- Flags framing errors and overruns; one instance per link, three per node.

Parameters:
- WIDTH, 32, instruction word width in bits.
- SYNC_STAGES, 2, synchroniser depth for sclk_in, cs_in and data_in; minimum 2.

Ports:
- clk  input  1  node clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sclk_in  input  1  link serial clock from the neighbour's master; asynchronous.
- cs_in  input  1  link chip-select, active-high; high for the duration of a frame.
- data_in  input  1  serial data, MSB first, stable around sclk_in rising edge.
- ack_in  input  1  queue has taken instr_out; clears check_out.
- instr_out  output  WIDTH  last accepted word.
- check_out  output  1  word valid; held until ack_in.
- frame_err  output  1  one-cycle pulse on a malformed frame.
- overrun  output  1  sticky; set when a good frame arrives while check_out=1.
- busy  output  1  high while a frame is in progress (state not IDLE).

Behaviour:
- Reset values: instr_out=0, check_out=0, frame_err=0, overrun=0, busy=0.
- On reset: FSM goes to IDLE, bit count 0, shift register 0.
- Reset mid-frame aborts the frame silently: no frame_err, nothing delivered.
- Synchronisers: each async input passes through SYNC_STAGES flops, plus one history flop for edge detection.
  - sclk rise = sync & ~hist.
  - cs rise and cs fall are defined the same way.
- Shift register: on each sclk rise while in SHIFT, shift {sr[WIDTH-2:0], data_sync} and increment cnt.
  - cnt is $clog2(WIDTH+2) bits and saturates at WIDTH+1.
- FSM states:
  - IDLE: on cs rise, clear cnt and go to SHIFT.
  - SHIFT: sclk rises shift data in. When cnt reaches WIDTH, go to FULL. On cs fall with cnt<WIDTH, pulse frame_err and go to IDLE.
  - FULL: waits for cs fall. Any further sclk rise pulses frame_err and moves to DRAIN. On cs fall, deliver and go to IDLE.
  - DRAIN: ignore data; on cs fall, go to IDLE with no delivery.
- Deliver:
  - If check_out=0: instr_out<=sr and check_out<=1.
  - If check_out=1: word dropped, overrun<=1, instr_out unchanged.
- Simultaneous deliver and ack_in in the same cycle: the ack clears the old word and the new word is accepted (check_out stays 1, instr_out updated, no overrun).
- ack_in while check_out=0 has no effect.
- overrun clears only on reset.
- Latency: cs_in low is first captured at edge N; with SYNC_STAGES=2, check_out and instr_out are valid after edge N+2.
- Link rate constraint: sclk_in high and low phases must each be at least SYNC_STAGES+1 clk periods. Faster links are out of spec and produce undefined data.
- cs rise while not in IDLE is impossible by construction (cs cannot rise while high) and is ignored.

Optional Feature:
- Macro: LINK_PARITY_EN.
- Defined:
  - Frame is WIDTH+1 bits; the final bit is even parity over the WIDTH data bits (XOR of all WIDTH+1 bits = 0).
  - FULL is reached at cnt=WIDTH+1. The parity bit is held in a separate flop and is not shifted into sr.
  - On cs fall in FULL with a parity mismatch: pulse frame_err and do not deliver.
- Undefined: frame is exactly WIDTH bits, there is no parity logic, and the described behaviour applies as written.

Decomposition:
- Shared package link_pkg:
  - FSM state enum (IDLE, SHIFT, FULL, DRAIN).
  - LINK_WIDTH=32 constant.
  - Count-width function.
- Sub-module link_sync: a SYNC_STAGES-deep synchroniser plus history flop, giving outputs sync, rise and fall.
  - Instantiated three times (sclk, cs, data); the data instance uses only sync.

Test Plan:
- Send 0xDEADBEEF, MSB first, sclk period 8 clk, then drop cs -> check_out=1 and instr_out=0xDEADBEEF after edge N+2; frame_err=0. Then ack_in for 1 cycle -> check_out=0.
- Send 0x00000001 and do not ack, then send 0xFFFFFFFF -> instr_out stays 0x00000001 and overrun=1. Then ack_in -> check_out=0 and overrun still 1.
- Drop cs after 20 bits -> one frame_err pulse; check_out stays 0; next full frame 0x12345678 is delivered cleanly.
- Send 33 sclk edges -> frame_err pulses on the 33rd edge, nothing delivered, FSM returns to IDLE at cs fall.
- Assert reset after 16 bits of a frame, release it, then send 0xA5A5A5A5 -> only 0xA5A5A5A5 is delivered; no frame_err.
- With LINK_PARITY_EN: 0x00000003 with parity bit 0 -> delivered; 0x00000007 with parity bit 0 -> frame_err and no delivery.
